// File: rtl/meteor_collision_ctrl.sv
// rtl/meteor_collision_ctrl.sv - per-frame meteor hit/crash accumulation, scoring and speed control
module meteor_collision_ctrl #(
    parameter int unsigned M1_Y           = 100,
    parameter int unsigned M2_Y           = 350,
    parameter int unsigned M3_Y           = 220,
    parameter int unsigned SIZE           = 30,
    parameter int unsigned RESPAWN_FRAMES = 4,
    parameter int unsigned BASE_SPEED     = 2,
    parameter int unsigned MAX_SPEED      = 8,
    parameter int unsigned M3_SCORE       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       video_active,
    input  logic [9:0] pix_y,
    input  logic       meteor_on,
    input  logic       shot_on,
    input  logic       ship_on,
    input  logic       restart,
    output logic       m1_alive,
    output logic       m2_alive,
    output logic       m3_alive,
    output logic [3:0] score,
    output logic [4:0] speed_out,
    output logic       hit_pulse,
    output logic       game_over
);
    typedef enum logic {ST_PLAY, ST_OVER} state_e;

    localparam logic [4:0] SPEED_RST = 5'(BASE_SPEED);
    localparam logic [3:0] CNT_RST   = 4'(RESPAWN_FRAMES);

    function automatic logic [4:0] speed_for(input logic [3:0] s);
        logic [5:0] t;
        t = 6'(BASE_SPEED) + {3'b000, s[3:1]};
        return (t > 6'(MAX_SPEED)) ? 5'(MAX_SPEED) : t[4:0];
    endfunction

    state_e          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [2:0]      alive_q, alive_d;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic [2:0]      hit_q, hit_d;
    logic            crash_q, crash_d;
    logic [3:0]      score_q, score_d;
    logic [4:0]      speed_q, speed_d;
    logic            hit_pulse_q, hit_pulse_d;
    logic            game_over_q, game_over_d;

    logic [31:0] y32;
    logic [2:0]  in_band, hit_en;
    logic        commit, shot_px, crash_px;
    logic [4:0]  score_sum;

    assign y32     = 32'(pix_y);
    assign in_band = {(y32 >= M3_Y) && (y32 < M3_Y + SIZE),
                      (y32 >= M2_Y) && (y32 < M2_Y + SIZE),
                      (y32 >= M1_Y) && (y32 < M1_Y + SIZE)};
    assign shot_px  = video_active & meteor_on & shot_on;
    assign crash_px = video_active & meteor_on & ship_on;
    // Meteor 3 only becomes shootable once the score reaches its threshold.
    assign hit_en   = {(score_q >= 4'(M3_SCORE)), 2'b11};
    assign commit   = s2_q & ~s3_q;
    assign score_sum = {1'b0, score_q} + {4'b0000, hit_q[0]}
                     + {4'b0000, hit_q[1]} + {4'b0000, hit_q[2]};

    always_comb begin
        state_d     = state_q;
        s1_d        = v_sync;
        s2_d        = s1_q;
        s3_d        = s2_q;
        alive_d     = alive_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        crash_d     = crash_q;
        score_d     = score_q;
        speed_d     = speed_q;
        hit_pulse_d = 1'b0;
        game_over_d = game_over_q;
        case (state_q)
            ST_PLAY: begin
                if (commit) begin
                    for (int k = 0; k < 3; k++) begin
                        if (hit_q[k]) begin
                            alive_d[k] = 1'b0;
                            cnt_d[k]   = CNT_RST;
                        end else if (!alive_q[k]) begin
                            if (cnt_q[k] == 4'd1) begin
                                alive_d[k] = 1'b1;
                                cnt_d[k]   = 4'd0;
                            end else if (cnt_q[k] != 4'd0) begin
                                cnt_d[k] = cnt_q[k] - 4'd1;
                            end
                        end
                    end
                    score_d     = (score_sum > 5'd15) ? 4'd15 : score_sum[3:0];
                    speed_d     = speed_for(score_d);
                    hit_pulse_d = |hit_q;
                    hit_d       = 3'b000;
                    crash_d     = 1'b0;
                    if (crash_q) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        alive_d     = 3'b000;
                    end
                end else begin
                    hit_d   = hit_q | (in_band & alive_q & hit_en & {3{shot_px}});
                    crash_d = crash_q | crash_px;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d     = ST_PLAY;
                    alive_d     = 3'b111;
                    cnt_d       = '0;
                    hit_d       = 3'b000;
                    crash_d     = 1'b0;
                    score_d     = 4'd0;
                    speed_d     = SPEED_RST;
                    game_over_d = 1'b0;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLAY;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            alive_q     <= 3'b111;
            cnt_q       <= '0;
            hit_q       <= 3'b000;
            crash_q     <= 1'b0;
            score_q     <= 4'd0;
            speed_q     <= SPEED_RST;
            hit_pulse_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            alive_q     <= alive_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            crash_q     <= crash_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            hit_pulse_q <= hit_pulse_d;
            game_over_q <= game_over_d;
        end
    end

    assign m1_alive  = alive_q[0];
    assign m2_alive  = alive_q[1];
    assign m3_alive  = alive_q[2];
    assign score     = score_q;
    assign speed_out = speed_q;
    assign hit_pulse = hit_pulse_q;
    assign game_over = game_over_q;
endmodule

// File: tb/tb_meteor_collision_ctrl.sv
// tb/tb_meteor_collision_ctrl.sv - frame-level reference model bench for meteor_collision_ctrl
module tb_meteor_collision_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, v_sync, video_active, meteor_on, shot_on, ship_on, restart;
    logic [9:0] pix_y;
    logic       m1_alive, m2_alive, m3_alive, hit_pulse, game_over;
    logic [3:0] score;
    logic [4:0] speed_out;

    meteor_collision_ctrl dut (
        .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .video_active(video_active),
        .pix_y(pix_y), .meteor_on(meteor_on), .shot_on(shot_on), .ship_on(ship_on),
        .restart(restart), .m1_alive(m1_alive), .m2_alive(m2_alive), .m3_alive(m3_alive),
        .score(score), .speed_out(speed_out), .hit_pulse(hit_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    bit e_alive [3];
    int e_cnt   [3];
    int e_score, e_speed;
    bit e_hp, e_over;
    bit f_hit   [3];
    bit f_crash;

    int band_top [3] = '{100, 350, 220};
    int edge_ys  [12] = '{99, 100, 129, 130, 349, 350, 379, 380, 219, 220, 249, 250};

    function automatic int band_of(input int y);
        for (int k = 0; k < 3; k++)
            if (y >= band_top[k] && y < band_top[k] + 30) return k;
        return -1;
    endfunction

    function automatic int speed_of(input int s);
        return (2 + s / 2 > 8) ? 8 : 2 + s / 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            e_alive[k] = 1'b1;
            e_cnt[k]   = 0;
            f_hit[k]   = 1'b0;
        end
        f_crash = 1'b0;
        e_score = 0;
        e_speed = 2;
        e_hp    = 1'b0;
        e_over  = 1'b0;
    endtask

    task automatic model_commit();
        int nh = 0;
        if (e_over) return;
        for (int k = 0; k < 3; k++) begin
            if (f_hit[k]) begin
                nh++;
                e_alive[k] = 1'b0;
                e_cnt[k]   = 4;
            end else if (!e_alive[k]) begin
                if (e_cnt[k] == 1) begin
                    e_alive[k] = 1'b1;
                    e_cnt[k]   = 0;
                end else if (e_cnt[k] > 0) begin
                    e_cnt[k]--;
                end
            end
            f_hit[k] = 1'b0;
        end
        e_score = (e_score + nh > 15) ? 15 : e_score + nh;
        e_speed = speed_of(e_score);
        e_hp    = (nh > 0);
        if (f_crash) begin
            e_over = 1'b1;
            for (int k = 0; k < 3; k++) e_alive[k] = 1'b0;
        end
        f_crash = 1'b0;
    endtask

    // Outputs are compared against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({m3_alive, m2_alive, m1_alive} !== {e_alive[2], e_alive[1], e_alive[0]} ||
                score !== 4'(e_score) || speed_out !== 5'(e_speed) ||
                hit_pulse !== e_hp || game_over !== e_over) begin
                errors++;
                $display("FAIL cycle t=%0t: got alive=%b score=%0d speed=%0d hp=%b go=%b, want alive=%b score=%0d speed=%0d hp=%b go=%b",
                         $time, {m3_alive, m2_alive, m1_alive}, score, speed_out, hit_pulse, game_over,
                         {e_alive[2], e_alive[1], e_alive[0]}, e_score, e_speed, e_hp, e_over);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int y, input bit va, input bit mo, input bit sh, input bit shp, input bit rs);
        int b;
        pix_y        = 10'(y);
        video_active = va;
        meteor_on    = mo;
        shot_on      = sh;
        ship_on      = shp;
        restart      = rs;
        if (!e_over) begin
            b = band_of(y);
            if (va && mo && sh && b >= 0 && e_alive[b] && (b != 2 || e_score >= 7)) f_hit[b] = 1'b1;
            if (va && mo && shp) f_crash = 1'b1;
        end
        step();
        if (e_over && rs) model_reset();
        video_active = 1'b0; meteor_on = 1'b0; shot_on = 1'b0; ship_on = 1'b0; restart = 1'b0;
    endtask

    task automatic commit_frame();
        v_sync = 1'b1;
        step(); step(); step();
        model_commit();
        step();
        e_hp = 1'b0;
        v_sync = 1'b0;
        repeat (4) step();
    endtask

    task automatic idle_frames(input int n);
        repeat (n) begin
            step();
            commit_frame();
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        if (e_over) model_reset();
        restart = 1'b0;
        step();
    endtask

    task automatic hit12();
        pix(110, 1, 1, 1, 0, 0);
        pix(360, 1, 1, 1, 0, 0);
        commit_frame();
    endtask

    function automatic int alive_vec();
        return int'({m3_alive, m2_alive, m1_alive});
    endfunction

    initial begin
        int y, n;
        rst_n = 1'b0; v_sync = 1'b0; video_active = 1'b0; pix_y = '0;
        meteor_on = 1'b0; shot_on = 1'b0; ship_on = 1'b0; restart = 1'b0;
        model_reset();
        chk_on = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();

        idle_frames(3);
        lit("idle_alive", alive_vec(), 7);
        lit("idle_score", int'(score), 0);
        lit("idle_speed", int'(speed_out), 2);

        pix(110, 1, 1, 1, 0, 0);
        commit_frame();
        lit("m1_hit_alive", alive_vec(), 6);
        lit("m1_hit_score", int'(score), 1);
        lit("model_score_1", e_score, 1);
        idle_frames(3);
        lit("m1_still_dead", int'(m1_alive), 0);
        idle_frames(1);
        lit("m1_respawn", int'(m1_alive), 1);

        hit12();
        lit("double_score", int'(score), 3);
        lit("double_alive", alive_vec(), 4);
        pix(230, 1, 1, 1, 0, 0);
        commit_frame();
        lit("m3_gated_score", int'(score), 3);
        lit("m3_gated_alive", int'(m3_alive), 1);
        idle_frames(3);
        hit12();
        idle_frames(4);
        hit12();
        lit("score_7", int'(score), 7);
        idle_frames(4);
        pix(230, 1, 1, 1, 0, 0);
        commit_frame();
        lit("m3_kill_alive", int'(m3_alive), 0);
        lit("m3_kill_score", int'(score), 8);
        lit("speed_8", int'(speed_out), 6);
        repeat (5) begin
            idle_frames(4);
            hit12();
        end
        lit("sat_score", int'(score), 15);
        lit("sat_speed", int'(speed_out), 8);
        lit("model_sat", e_score, 15);

        pix(110, 1, 1, 1, 0, 0);
        idle_frames(3);
        pix(110, 1, 1, 1, 0, 0);
        rst_n = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();
        lit("rst_score", int'(score), 0);
        commit_frame();
        lit("rst_no_hit_score", int'(score), 0);
        lit("rst_no_hit_alive", alive_vec(), 7);

        pix(110, 1, 1, 1, 0, 0);
        pix(500, 1, 1, 0, 1, 0);
        commit_frame();
        lit("crash_score", int'(score), 1);
        lit("crash_over", int'(game_over), 1);
        lit("crash_alive", alive_vec(), 0);
        pix(360, 1, 1, 1, 0, 0);
        commit_frame();
        lit("over_ignored", int'(score), 1);
        do_restart();
        lit("restart_score", int'(score), 0);
        lit("restart_alive", alive_vec(), 7);
        lit("restart_over", int'(game_over), 0);

        repeat (250) begin
            n = $urandom_range(3, 40);
            repeat (n) begin
                case ($urandom_range(0, 2))
                    0: y = $urandom_range(0, 1023);
                    1: y = band_top[$urandom_range(0, 2)] + $urandom_range(0, 29);
                    default: y = edge_ys[$urandom_range(0, 11)];
                endcase
                pix(y, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 15) == 0);
            end
            commit_frame();
            if (e_over && $urandom_range(0, 2) == 0) do_restart();
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
